// File: rtl/glove_pkg.sv
// glove_pkg
// Shared definitions for the glove letter/word output path: loader and UART
// transmitter state enums, ASCII constants, letter-code width and the byte
// mapping helper.
// Configuration macro: LETTER_ASCII_EN
//   defined   - codes 1..26 map to 'A'..'Z', code 0 maps to space,
//               codes 27..255 pass through unchanged
//   undefined - bytes are sent raw
package glove_pkg;

  localparam int LETTER_W = 8;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {L_IDLE, L_BYTES, L_CR, L_LF} loader_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  // Applied to letter and word bytes only; the CR/LF terminator bypasses it.
  function automatic logic [7:0] map_byte(input logic [LETTER_W-1:0] code);
`ifdef LETTER_ASCII_EN
    if (code == 8'd0)
      return ASCII_SP;
    else if (code <= 8'd26)
      return ASCII_A + code - 8'd1;
    else
      return code;
`else
    return code;
`endif
  endfunction

endpackage

// File: rtl/letter_uart_tx_if.sv
// letter_uart_tx_if
// Letter/word output interface of the glove recognizer.
//   i_letter_valid  one-cycle strobe, new letter in i_letter
//   i_letter        letter code
//   i_word_valid    one-cycle strobe, word finished
//   i_word          15 bytes, byte k at [8k+7:8k], byte 0 first
//   i_length        number of valid word bytes, 0..15
// Modports: master = recognizer (drives), slave = serializer (receives).
interface letter_uart_tx_if;
  import glove_pkg::*;

  logic                i_letter_valid;
  logic [LETTER_W-1:0] i_letter;
  logic                i_word_valid;
  logic [119:0]        i_word;
  logic [3:0]          i_length;

  modport master (output i_letter_valid, i_letter, i_word_valid, i_word, i_length);
  modport slave  (input  i_letter_valid, i_letter, i_word_valid, i_word, i_length);
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo
// Synchronous byte FIFO with show-ahead read data.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   write request and data
//   i_pop            read request; o_data is the current head
//   o_full, o_empty  status
//   o_level          occupancy, 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
module byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (level == LW'(DEPTH));
  assign o_empty = (level == '0);
  assign o_level = level;
  assign o_data  = mem[rd_ptr];

  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push)
      mem[wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        level <= level + LW'(1);
      else if (do_pop && !do_push)
        level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/letter_uart_tx.sv
// letter_uart_tx
// Serializes recognizer letters and finished words onto an 8N1 UART line.
// Letters are pushed directly; words go through a loader that emits the word
// bytes followed by CR LF. A byte FIFO decouples pushes from the transmitter.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   bus             letter/word strobes (letter_uart_tx_if.slave)
//   i_ovf_clr       one-cycle clear of o_overflow
//   o_tx            UART line, idle high
//   o_busy          loader active, FIFO non-empty or frame in flight
//   o_overflow      sticky drop flag (set wins over clear)
//   o_fifo_level    FIFO occupancy
// Configuration macro: LETTER_ASCII_EN (see glove_pkg::map_byte).
module letter_uart_tx
  import glove_pkg::*;
#(
  parameter  int BAUD_DIV   = 434,
  parameter  int FIFO_DEPTH = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  letter_uart_tx_if.slave  bus,
  input  logic             i_ovf_clr,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_overflow,
  output logic [LVL_W-1:0] o_fifo_level
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  loader_state_t    l_state, l_next;
  tx_state_t        t_state, t_next;
  logic [14:0][7:0] word_q;
  logic [3:0]       len_q;
  logic [3:0]       idx_q;
  logic             latch_word;
  logic             idx_inc;
  logic             loader_want;
  logic             loader_push;
  logic [7:0]       loader_byte;

  logic             fifo_push;
  logic [7:0]       fifo_wdata;
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             can_push;

  logic [15:0]      baud_cnt;
  logic             baud_done;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             load;
  logic             shift;
  logic             ovf_set;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_data  (fifo_wdata),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_fifo_level)
  );

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign can_push   = !fifo_full || fifo_pop;
  assign fifo_push  = bus.i_letter_valid || loader_push;
  assign fifo_wdata = bus.i_letter_valid ? map_byte(bus.i_letter) : loader_byte;

  always_comb begin
    l_next      = l_state;
    loader_want = 1'b0;
    loader_byte = ASCII_CR;
    latch_word  = 1'b0;
    idx_inc     = 1'b0;
    case (l_state)
      L_BYTES: begin
        loader_want = 1'b1;
        loader_byte = map_byte(word_q[idx_q]);
      end
      L_CR: begin
        loader_want = 1'b1;
        loader_byte = ASCII_CR;
      end
      L_LF: begin
        loader_want = 1'b1;
        loader_byte = ASCII_LF;
      end
      default: ;
    endcase
    // Letters own the FIFO write port; the loader waits rather than drops.
    loader_push = loader_want && !bus.i_letter_valid && can_push;
    case (l_state)
      L_IDLE: begin
        if (bus.i_word_valid) begin
          latch_word = 1'b1;
          l_next     = (bus.i_length == 4'd0) ? L_CR : L_BYTES;
        end
      end
      L_BYTES: begin
        if (loader_push) begin
          if (idx_q == len_q - 4'd1) l_next = L_CR;
          else                       idx_inc = 1'b1;
        end
      end
      L_CR:    if (loader_push) l_next = L_LF;
      L_LF:    if (loader_push) l_next = L_IDLE;
      default: l_next = L_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      l_state <= L_IDLE;
      word_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      l_state <= l_next;
      if (latch_word) begin
        word_q <= bus.i_word;
        len_q  <= bus.i_length;
        idx_q  <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  assign baud_done = (baud_cnt == BAUD_LAST);

  // T_STOP pops straight into T_START so consecutive frames have no gap.
  always_comb begin
    t_next   = t_state;
    fifo_pop = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    case (t_state)
      T_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          t_next   = T_START;
        end
      end
      T_START: if (baud_done) t_next = T_DATA;
      T_DATA: begin
        if (baud_done) begin
          shift = 1'b1;
          if (bit_cnt == 3'd7) t_next = T_STOP;
        end
      end
      T_STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
            t_next   = T_START;
          end else begin
            t_next = T_IDLE;
          end
        end
      end
      default: t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      t_state  <= T_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      t_state <= t_next;
      if (t_state == T_IDLE || baud_done) baud_cnt <= '0;
      else                                baud_cnt <= baud_cnt + 16'd1;
      if (load)       bit_cnt <= '0;
      else if (shift) bit_cnt <= bit_cnt + 3'd1;
      if (load)       shreg <= fifo_rdata;
      else if (shift) shreg <= {1'b0, shreg[7:1]};
    end
  end

  // The line is decoded from state registers so reset forces it high at once.
  always_comb begin
    case (t_state)
      T_START: o_tx = 1'b0;
      T_DATA:  o_tx = shreg[0];
      default: o_tx = 1'b1;
    endcase
  end

  assign o_busy  = (l_state != L_IDLE) || !fifo_empty || (t_state != T_IDLE);
  assign ovf_set = (bus.i_letter_valid && !can_push) ||
                   (bus.i_word_valid && (l_state != L_IDLE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       o_overflow <= 1'b0;
    else if (ovf_set)   o_overflow <= 1'b1;
    else if (i_ovf_clr) o_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_letter_uart_tx.sv
// tb_letter_uart_tx
// Scoreboard bench for letter_uart_tx with BAUD_DIV=4, FIFO_DEPTH=4.
// Stimulus pushes expected bytes into a queue; a UART monitor decodes o_tx
// frames and compares each received byte against the queue head.
module tb_letter_uart_tx;
  import glove_pkg::*;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] level;

  letter_uart_tx_if bus ();

  letter_uart_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .bus          (bus.slave),
    .i_ovf_clr    (ovf_clr),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_overflow   (overflow),
    .o_fifo_level (level)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  longint     cyc = 0;
  bit         mon_active = 0;
  int         mon_k = 0;
  logic [7:0] mon_byte;
  int         frames_seen = 0;
  bit         gap_check = 0;
  bit         prev_valid = 0;
  longint     prev_start = 0;
  int         frames_before;

  // Hand-derived byte mapping for the configured build.
  function automatic logic [7:0] mapByte(input logic [7:0] c);
`ifdef LETTER_ASCII_EN
    if (c == 8'h00)      return 8'h20;
    else if (c <= 8'd26) return 8'h40 + c;
    else                 return c;
`else
    return c;
`endif
  endfunction

  function automatic logic [119:0] packWord(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
    logic [119:0] w;
    w = '0;
    w[7:0]   = b0;
    w[15:8]  = b1;
    w[23:16] = b2;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs starting just after a rising edge.
  task automatic applyStimulus(input logic lv, input logic [7:0] lc, input logic wv,
                               input logic [119:0] w, input logic [3:0] len, input logic clr);
    bus.i_letter_valid = lv;
    bus.i_letter       = lc;
    bus.i_word_valid   = wv;
    bus.i_word         = w;
    bus.i_length       = len;
    ovf_clr            = clr;
    @(posedge clk);
    #1;
    bus.i_letter_valid = 1'b0;
    bus.i_word_valid   = 1'b0;
    ovf_clr            = 1'b0;
  endtask

  task automatic waitIdle(input int bound, input string name);
    int n;
    n = 0;
    while ((busy || mon_active || exp_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " idle within bound"}, {31'd0, busy | mon_active}, 32'd0);
    checkOutput({name, " frames outstanding"}, exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // UART monitor: decodes frames at mid-bit on falling clock edges.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mon_active = 0;
        prev_valid = 0;
      end else if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1;
          mon_k = 0;
          frames_seen++;
          if (gap_check && prev_valid)
            checkOutput("frame spacing", 32'(cyc - prev_start), FRAME);
          prev_start = cyc;
          prev_valid = 1;
        end
      end else begin
        mon_k++;
        if (mon_k == BAUD / 2) begin
          checkOutput("start bit", {31'd0, tx}, 32'd0);
        end else if (mon_k < 9 * BAUD && (mon_k % BAUD) == BAUD / 2) begin
          mon_byte[mon_k / BAUD - 1] = tx;
        end else if (mon_k == 9 * BAUD + BAUD / 2) begin
          checkOutput("stop bit", {31'd0, tx}, 32'd1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected frame: got 0x%0h, expected no frame", mon_byte);
          end else begin
            checkOutput("frame byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
          end
          mon_active = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_letter_valid = 1'b0;
    bus.i_letter       = '0;
    bus.i_word_valid   = 1'b0;
    bus.i_word         = '0;
    bus.i_length       = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset tx", {31'd0, tx}, 32'd1);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset level", {29'd0, level}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single letter
    exp_q.push_back(mapByte(8'h03));
    applyStimulus(1'b1, 8'h03, 1'b0, '0, 4'd0, 1'b0);
    checkOutput("level after letter", {29'd0, level}, 32'd1);
    checkOutput("busy after letter", {31'd0, busy}, 32'd1);
    waitIdle(100, "single");

    // Word, back-to-back frames
    frames_before = frames_seen;
    prev_valid = 0;
    gap_check = 1;
    exp_q.push_back(mapByte(8'h08));
    exp_q.push_back(mapByte(8'h09));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    applyStimulus(1'b0, 8'h00, 1'b1, packWord(8'h08, 8'h09, 8'h00), 4'd2, 1'b0);
    waitIdle(300, "word");
    gap_check = 0;
    checkOutput("word frame count", frames_seen - frames_before, 32'd4);

    // Overflow: letters 1..5 fit (one is popped early), letter 6 is dropped
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(mapByte(8'(i)));
      applyStimulus(1'b1, 8'(i), 1'b0, '0, 4'd0, 1'b0);
    end
    checkOutput("level full", {29'd0, level}, 32'd4);
    checkOutput("overflow set", {31'd0, overflow}, 32'd1);
    applyStimulus(1'b1, 8'h07, 1'b0, '0, 4'd0, 1'b1);
    checkOutput("overflow set wins over clear", {31'd0, overflow}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, '0, 4'd0, 1'b1);
    checkOutput("overflow cleared", {31'd0, overflow}, 32'd0);
    waitIdle(400, "overflow");

    // Collision: letter lands between word bytes; extra word while busy is ignored
    exp_q.push_back(mapByte(8'h11));
    exp_q.push_back(mapByte(8'h1A));
    exp_q.push_back(mapByte(8'h12));
    exp_q.push_back(mapByte(8'h13));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    applyStimulus(1'b0, 8'h00, 1'b1, packWord(8'h11, 8'h12, 8'h13), 4'd3, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, '0, 4'd0, 1'b0);
    applyStimulus(1'b1, 8'h1A, 1'b0, '0, 4'd0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, packWord(8'h14, 8'h00, 8'h00), 4'd1, 1'b0);
    checkOutput("overflow on busy word", {31'd0, overflow}, 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, '0, 4'd0, 1'b1);
    checkOutput("overflow cleared again", {31'd0, overflow}, 32'd0);
    waitIdle(500, "collision");

    // Zero length word
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    applyStimulus(1'b0, 8'h00, 1'b1, '0, 4'd0, 1'b0);
    waitIdle(200, "zero length");

    // Mid-frame reset
    exp_q.push_back(mapByte(8'h80));
    exp_q.push_back(mapByte(8'h81));
    applyStimulus(1'b1, 8'h80, 1'b0, '0, 4'd0, 1'b0);
    applyStimulus(1'b1, 8'h81, 1'b0, '0, 4'd0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("tx low in data bit", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("tx high on reset", {31'd0, tx}, 32'd1);
    checkOutput("level zero on reset", {29'd0, level}, 32'd0);
    checkOutput("busy low on reset", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    frames_before = frames_seen;
    repeat (100) @(negedge clk);
    checkOutput("no frames after reset", frames_seen - frames_before, 32'd0);
    checkOutput("tx idle after reset", {31'd0, tx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/letter_uart_tx.md
# letter_uart_tx

Output-side serializer for the glove recognizer. Consumes the recognizer's letter strobe and word-finished strobe, converts letters and finished words into a byte stream, buffers it in a FIFO, and transmits it on a single 8N1 UART line to the host or display MCU. It is the receiving end of the recognizer's letter/word output interface and the only path from recognition results to the outside world.

## Interface
- BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
- FIFO_DEPTH, 16, byte FIFO depth; power of two, 4..64
- i_clk  in  1  system clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_letter_valid  in  1  one-cycle strobe: new letter available
- i_letter  in  8  letter code, sampled with i_letter_valid
- i_word_valid  in  1  one-cycle strobe: word finished
- i_word  in  120  word, byte k at [8k+7:8k], byte 0 first
- i_length  in  4  number of valid word bytes, 0..15
- i_ovf_clr  in  1  one-cycle clear of o_overflow
- o_tx  out  1  UART line, idle high
- o_busy  out  1  loader active, or FIFO non-empty, or frame in flight
- o_overflow  out  1  sticky: a byte or word was dropped
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset values: o_tx=1, o_busy=0, o_overflow=0, o_fifo_level=0; FIFO empty, loader and TX FSM idle.
- Letter path: i_letter_valid pushes one byte (mapped per Configuration) in the same cycle.
- Word path: i_word_valid latches i_word/i_length into the loader. The loader then pushes bytes 0..i_length-1 in order, one per cycle, followed by 0x0D, 0x0A. i_length=0 yields only CR LF.
- Loader states: L_IDLE, L_BYTES, L_CR, L_LF; L_LF returns to L_IDLE after its push.
- One FIFO push per cycle. A letter push has priority; the loader stalls that cycle.
- The loader stalls while the FIFO is full and never drops bytes.
- A letter arriving while the FIFO is full is dropped, and o_overflow is set.
- i_word_valid while the loader is not in L_IDLE is ignored, and o_overflow is set.
- o_overflow: set by any drop; cleared by i_ovf_clr. If a set and a clear occur in the same cycle, the set wins.
- TX FSM states: T_IDLE, T_START, T_DATA, T_STOP.
  - T_IDLE with FIFO non-empty: pop, load the shift register, go to T_START.
  - Each state lasts BAUD_DIV cycles.
  - T_DATA sends 8 bits LSB-first, using a 3-bit bit counter.
  - T_STOP drives 1. It then goes to T_IDLE, or pops directly into T_START when the FIFO is non-empty, so back-to-back frames have no gap.
- A push and a pop in the same cycle are both legal; level is unchanged, including when the FIFO is full.
- Reset asserted mid-frame: o_tx returns to 1 immediately; FIFO, loader and partial frame are discarded.

## Timing
- A letter strobe at edge N makes the FIFO non-empty after N. The pop occurs at N+1 and o_tx falls after N+1, so latency is 1 cycle from FIFO to line.
- Frame length is exactly 10*BAUD_DIV cycles: start bit, 8 data bits, stop bit.
- The loader issues its first push at the edge after the i_word_valid edge. An unstalled word occupies i_length+2 consecutive cycles.
- o_fifo_level and o_busy are registered and reflect the state after each edge.

## Configuration
- LETTER_ASCII_EN
  - Defined: letter and word bytes with code 1..26 are mapped to 0x41..0x5A ('A'..'Z'); code 0 is mapped to 0x20; codes 27..255 pass through unchanged.
  - Undefined: bytes are sent raw.
- The CR/LF terminator bytes are never mapped.

## Structure
- Shared package glove_pkg holds:
  - the loader and TX state enums;
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_A=8'h41, ASCII_SP=8'h20;
  - the letter-code width.
- Sub-module byte_fifo provides a synchronous FIFO: 8-bit data, parameterized depth, full/empty/level outputs, same-cycle push and pop.

## Test plan
All scenarios use BAUD_DIV=4 and FIFO_DEPTH=4.
- Single letter: i_letter=8'h03 with LETTER_ASCII_EN -> o_tx frame bits 0,1,1,0,0,0,0,1,0,1 (0x43 LSB-first), each 4 cycles; o_busy drops after 40 cycles.
- Word: i_word bytes 0x08,0x09, i_length=2, ASCII on -> bytes 0x48,0x49,0x0D,0x0A sent back-to-back in 160 cycles with no idle gap.
- Overflow: 6 letter strobes on consecutive cycles -> at least 1 dropped, o_overflow=1. Then i_ovf_clr -> o_overflow=0.
- Collision: i_letter_valid during loader L_BYTES -> letter byte inserted between word bytes, no word byte lost.
- Zero length: i_length=0 -> only 0x0D, 0x0A transmitted.
- Mid-frame reset: assert i_rst_n=0 during T_DATA -> o_tx=1 and o_fifo_level=0 immediately; no further frames transmitted.
